mult_hilo_ctrl: RTL
===================

MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be exactly as listed in REQ-002 to REQ-014.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous reset, active low.
REQ-004 exe_valid  input  1  execute stage presents an instruction this cycle.
REQ-005 exe_op  input  3  opcode: 0 NONE, 1 MULT, 2 MFHI, 3 MFLO, 4 MTHI, 5 MTLO; 6 and 7 SHALL be treated as NONE.
REQ-006 exe_src1, exe_src2  input  32 each  operands; MULT uses both, MTHI/MTLO use exe_src1.
REQ-007 mult_end  input  1  done strobe from the iterative signed multiplier.
REQ-008 product  input  64  multiplier result, valid while mult_end=1.
REQ-009 mult_begin  output  1  multiplier start/hold level.
REQ-010 mult_op1, mult_op2  output  32 each  registered operands to the multiplier.
REQ-011 exe_stall  output  1  execute stage SHALL hold its instruction while high.
REQ-012 hilo_rdata  output  32  MFHI/MFLO read data.
REQ-013 hi, lo  output  32 each  architectural HI/LO registers.
REQ-014 busy  output  1  high while state is not IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-016 Transitions:
  - IDLE→BUSY on accepted MULT.
  - BUSY→DONE on the cycle mult_end=1.
  - DONE→IDLE unconditionally after one cycle.
REQ-017 An op is accepted when exe_valid=1, the op is not NONE and exe_stall=0.
REQ-018 An accepted MULT SHALL register exe_src1/exe_src2 into mult_op1/mult_op2 at the same edge; the MULT itself SHALL NOT stall.
REQ-019 mult_begin SHALL equal (state==BUSY).
  - It holds high for the whole operation.
  - It is low for at least the one DONE cycle between consecutive multiplies, so the multiplier clears its valid flag.
REQ-020 In BUSY, when mult_end=1, hi←product[63:32] and lo←product[31:0] at that edge.
REQ-021 exe_stall SHALL be 1 when exe_valid=1 and either:
  - state is BUSY and op is any non-NONE op; or
  - state is DONE and op is MULT.
  All other cases SHALL give exe_stall=0, subject to REQ-031.
REQ-022 An accepted MTHI writes hi←exe_src1, and an accepted MTLO writes lo←exe_src1, at the edge ending the accept cycle; this is legal only in IDLE or DONE.
REQ-023 hilo_rdata SHALL be combinational:
  - hi when exe_op=MFHI;
  - lo when exe_op=MFLO;
  - 0 otherwise.
  It is only consumed when exe_stall=0.
REQ-024 Latency: a MULT accepted in cycle T produces mult_begin=1 from T+1. HI/LO are visible in the cycle after mult_end. The earliest non-stalled MFHI/MFLO is the DONE cycle.
REQ-025 A zero operand SHALL need no special case: the multiplier asserts mult_end on its first valid cycle and the FSM proceeds normally.
REQ-026 If exe_valid drops while BUSY, the multiply SHALL continue to completion.

Reset
REQ-027 While resetn=0, the block SHALL immediately force state=IDLE, hi=lo=0, mult_op1=mult_op2=0 and mult_begin=0, without waiting for a clock edge.
REQ-028 Given REQ-027, busy=0 and exe_stall=0 during reset; hilo_rdata follows REQ-023, i.e. 0 for non-MFHI/MFLO ops.
REQ-029 Reset during BUSY SHALL abandon the multiply; the multiplier self-clears because mult_begin is low. HI/LO SHALL remain 0 until the next write.

Configuration
REQ-030 The macro HILO_FWD_EN SHALL select whether MFHI/MFLO results are forwarded from the multiplier.
REQ-031 With HILO_FWD_EN defined, an MFHI/MFLO in BUSY on the cycle mult_end=1 SHALL NOT stall:
  - hilo_rdata = product[63:32] for MFHI;
  - hilo_rdata = product[31:0] for MFLO.
REQ-032 Without HILO_FWD_EN, the case in REQ-031 SHALL stall and be served from hi/lo in DONE.

Verification
REQ-033 MULT 3 × 0xFFFFFFFE → hi=0xFFFFFFFF, lo=0xFFFFFFFA after DONE; busy returns to 0.
REQ-034 MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000.
REQ-035 MULT then MFHI next cycle → exe_stall=1 through BUSY. Without the macro, 0 in DONE with the correct hilo_rdata; with HILO_FWD_EN, 0 on the mult_end cycle.
REQ-036 Back-to-back MULT (5×7 then 2×2):
  - the second MULT stalls in DONE;
  - mult_begin is low for exactly one cycle between the two operations;
  - final lo=4.
REQ-037 MTLO 0x00001234, then MFLO → hilo_rdata=0x00001234 with exe_stall=0.
REQ-038 resetn pulled low mid-BUSY → hi=lo=0, mult_begin=0 and busy=0 immediately; a subsequent MULT 6×7 yields lo=42.

Source files
------------

// File: rtl/mult_hilo_ctrl.sv
// HI/LO register file and sequencing control for an iterative signed multiplier.
// Optional build macro HILO_FWD_EN forwards the product to MFHI/MFLO on the mult_end cycle.
module mult_hilo_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        exe_valid,
   input  logic [2:0]  exe_op,
   input  logic [31:0] exe_src1,
   input  logic [31:0] exe_src2,
   input  logic        mult_end,
   input  logic [63:0] product,
   output logic        mult_begin,
   output logic [31:0] mult_op1,
   output logic [31:0] mult_op2,
   output logic        exe_stall,
   output logic [31:0] hilo_rdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy
);

   localparam logic [2:0] OP_MULT = 3'd1;
   localparam logic [2:0] OP_MFHI = 3'd2;
   localparam logic [2:0] OP_MFLO = 3'd3;
   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [31:0] hi_r;
   logic [31:0] lo_r;
   logic [31:0] op1_r;
   logic [31:0] op2_r;
   logic        op_mult_s;
   logic        op_mfhi_s;
   logic        op_mflo_s;
   logic        op_mthi_s;
   logic        op_mtlo_s;
   logic        op_any_s;
   logic        fwd_hit_s;
   logic        stall_s;
   logic        accept_s;
   logic        mult_fin_s;
   logic [31:0] rdata_s;

   // Opcode decode; codes 6 and 7 decode to nothing and behave as NONE.
   always_comb begin
      op_mult_s = (exe_op == OP_MULT);
      op_mfhi_s = (exe_op == OP_MFHI);
      op_mflo_s = (exe_op == OP_MFLO);
      op_mthi_s = (exe_op == OP_MTHI);
      op_mtlo_s = (exe_op == OP_MTLO);
      op_any_s  = op_mult_s | op_mfhi_s | op_mflo_s | op_mthi_s | op_mtlo_s;
   end

   assign mult_fin_s = (state_r == ST_BUSY) && mult_end;

`ifdef HILO_FWD_EN
   assign fwd_hit_s = mult_fin_s && (op_mfhi_s || op_mflo_s);
`else
   assign fwd_hit_s = 1'b0;
`endif

   // Stall generation: BUSY blocks all ops (except a forwarded read), DONE blocks a new MULT.
   always_comb begin
      stall_s = 1'b0;
      if (exe_valid) begin
         case (state_r)
            ST_BUSY: stall_s = op_any_s && !fwd_hit_s;
            ST_DONE: stall_s = op_mult_s;
            default: stall_s = 1'b0;
         endcase
      end else begin
         stall_s = 1'b0;
      end
   end

   assign accept_s = exe_valid && op_any_s && !stall_s;

   // Next-state logic; a MULT can only be accepted from IDLE since DONE stalls it.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && op_mult_s) begin
               state_next_s = ST_BUSY;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mult_end) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_BUSY;
            end
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Read mux: forwarded product on the finishing cycle, otherwise the architectural registers.
   always_comb begin
      rdata_s = 32'h0000_0000;
      if (fwd_hit_s) begin
         if (op_mfhi_s) begin
            rdata_s = product[63:32];
         end else begin
            rdata_s = product[31:0];
         end
      end else begin
         case (exe_op)
            OP_MFHI: rdata_s = hi_r;
            OP_MFLO: rdata_s = lo_r;
            default: rdata_s = 32'h0000_0000;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Multiplier operand capture on an accepted MULT.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op1_r <= 32'h0000_0000;
         op2_r <= 32'h0000_0000;
      end else if (accept_s && op_mult_s) begin
         op1_r <= exe_src1;
         op2_r <= exe_src2;
      end else begin
         op1_r <= op1_r;
         op2_r <= op2_r;
      end
   end

   // HI/LO update: product write wins; MTHI/MTLO are only ever accepted outside BUSY.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_r <= 32'h0000_0000;
         lo_r <= 32'h0000_0000;
      end else if (mult_fin_s) begin
         hi_r <= product[63:32];
         lo_r <= product[31:0];
      end else begin
         if (accept_s && op_mthi_s) begin
            hi_r <= exe_src1;
         end else begin
            hi_r <= hi_r;
         end
         if (accept_s && op_mtlo_s) begin
            lo_r <= exe_src1;
         end else begin
            lo_r <= lo_r;
         end
      end
   end

   assign mult_begin = (state_r == ST_BUSY);
   assign busy       = (state_r != ST_IDLE);
   assign mult_op1   = op1_r;
   assign mult_op2   = op2_r;
   assign exe_stall  = stall_s;
   assign hilo_rdata = rdata_s;
   assign hi         = hi_r;
   assign lo         = lo_r;

endmodule
